// File: rtl/srv32_dbus_router.sv
`default_nettype none
// ============================================================================
// srv32_dbus_router : address-decoded data-bus router, one master to NTGT targets
// Revision 1.0
// ============================================================================
module srv32_dbus_router #(
    parameter int unsigned       NTGT     = 2,
    parameter logic [4*NTGT-1:0] TGT_BASE = {4'h2, 4'h0},
    parameter int unsigned       DEF_TGT  = 0,
    parameter int unsigned       ECNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 m_wready,
    output logic                 m_wvalid,
    input  logic [31:0]          m_waddr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_wstrb,
    input  logic                 m_rready,
    output logic                 m_rvalid,
    input  logic [31:0]          m_raddr,
    output logic                 m_rresp,
    output logic [31:0]          m_rdata,
    output logic [NTGT-1:0]      s_wready,
    input  logic [NTGT-1:0]      s_wvalid,
    output logic [31:0]          s_waddr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    output logic [NTGT-1:0]      s_rready,
    input  logic [NTGT-1:0]      s_rvalid,
    output logic [31:0]          s_raddr,
    input  logic [NTGT-1:0]      s_rresp,
    input  logic [NTGT*32-1:0]   s_rdata,
    input  logic                 err_clr,
    output logic                 err_valid,
    output logic [31:0]          err_addr,
    output logic [ECNT_W-1:0]    err_cnt
);

    localparam int unsigned       SW      = $clog2(NTGT + 1);
    localparam logic [SW-1:0]     ERR     = SW'(NTGT);
    localparam logic [ECNT_W-1:0] CNT_MAX = {ECNT_W{1'b1}};
    localparam logic [ECNT_W+1:0] CNT_MAX_X = {2'b00, CNT_MAX};

    // Descending scan so the lowest matching index is the last one written.
    function automatic logic [SW-1:0] decode(input logic [31:0] addr);
        logic [SW-1:0] sel;
        sel = SW'(DEF_TGT);
        for (int i = int'(NTGT) - 1; i >= 0; i--) begin
            if (addr[31:28] == TGT_BASE[4*i +: 4]) sel = SW'(i);
        end
        return sel;
    endfunction

    logic [SW-1:0]     wsel, rsel;
    logic              werr, rerr;
    logic              rd_acc, werr_acc, rerr_acc, new_err;
    logic [1:0]        err_inc;
    logic [ECNT_W-1:0] cnt_base;
    logic [ECNT_W+1:0] cnt_sum;
    logic [31:0]       ret_data;
    logic              ret_resp;

    logic [SW-1:0]     rsel_q, rsel_d;
    logic              rpend_q, rpend_d;
    logic              err_valid_q, err_valid_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;

    assign wsel = decode(m_waddr);
    assign rsel = decode(m_raddr);
    assign werr = (wsel == ERR);
    assign rerr = (rsel == ERR);

    assign s_waddr = m_waddr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;
    assign s_raddr = m_raddr;

    // Error-decoded requests are accepted immediately with no target request.
    always_comb begin
        s_wready = '0;
        s_rready = '0;
        m_wvalid = werr;
        m_rvalid = rerr;
        for (int i = 0; i < int'(NTGT); i++) begin
            if (wsel == SW'(i)) begin
                s_wready[i] = m_wready;
                m_wvalid    = s_wvalid[i];
            end
            if (rsel == SW'(i)) begin
                s_rready[i] = m_rready;
                m_rvalid    = s_rvalid[i];
            end
        end
    end

    always_comb begin
        ret_data = '0;
        ret_resp = 1'b0;
        for (int i = 0; i < int'(NTGT); i++) begin
            if (rsel_q == SW'(i)) begin
                ret_data = s_rdata[32*i +: 32];
                ret_resp = s_rresp[i];
            end
        end
    end

    assign m_rdata = ret_data;
    assign m_rresp = rpend_q ? ret_resp : 1'b1;

    assign rd_acc   = m_rready & m_rvalid;
    assign werr_acc = m_wready & werr;
    assign rerr_acc = m_rready & rerr;
    assign new_err  = werr_acc | rerr_acc;
    assign err_inc  = {1'b0, werr_acc} + {1'b0, rerr_acc};

    // A clear in the same cycle as a new error restarts the count from zero.
    always_comb begin
        rsel_d      = rd_acc ? rsel : rsel_q;
        rpend_d     = rd_acc;
        cnt_base    = err_clr ? '0 : err_cnt_q;
        cnt_sum     = {2'b00, cnt_base} + {{ECNT_W{1'b0}}, err_inc};
        err_cnt_d   = (cnt_sum > CNT_MAX_X) ? CNT_MAX : cnt_sum[ECNT_W-1:0];
        err_valid_d = (err_valid_q & ~err_clr) | new_err;
        err_addr_d  = err_addr_q;
        if (new_err && (!err_valid_q || err_clr)) begin
            err_addr_d = rerr_acc ? m_raddr : m_waddr;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rsel_q      <= '0;
            rpend_q     <= 1'b0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            rsel_q      <= rsel_d;
            rpend_q     <= rpend_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
